// File: rtl/alu_cmd_sequencer.sv
// Command-side sequencer for the signed ALU: accepts one command, pulses the selected
// unit's enable, waits (with a watchdog) for its flag and returns the captured word.
module alu_cmd_sequencer #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 8
) (
  input  logic             CLK,
  input  logic             RST,
  // command port
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_fun,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  // execution-unit side
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [1:0]       ALU_FUN,
  output logic             Arith_Enable,
  output logic             Logic_Enable,
  output logic             CMP_Enable,
  output logic             SHIFT_Enable,
  input  logic [WIDTH-1:0] Arith_OUT,
  input  logic [WIDTH-1:0] Logic_OUT,
  input  logic [WIDTH-1:0] CMP_OUT,
  input  logic [WIDTH-1:0] SHIFT_OUT,
  input  logic             Arith_Flag,
  input  logic             Logic_Flag,
  input  logic             CMP_Flag,
  input  logic             SHIFT_Flag,
  // result port
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [1:0]       res_unit,
  output logic             res_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // Last WAIT count: the timeout fires on the TIMEOUT-th WAIT cycle.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  state_e           state_q,     state_d;
  logic [1:0]       unit_q,      unit_d;
  logic [WIDTH-1:0] a_q,         a_d;
  logic [WIDTH-1:0] b_q,         b_d;
  logic [1:0]       fun_q,       fun_d;
  logic [3:0]       en_q,        en_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q,  res_data_d;
  logic [1:0]       res_unit_q,  res_unit_d;
  logic             res_err_q,   res_err_d;
  logic [CW-1:0]    cnt_q,       cnt_d;

  logic             sel_flag;
  logic [WIDTH-1:0] sel_out;

  // Only the unit latched at accept is listened to; other flags are ignored.
  always_comb begin
    sel_flag = 1'b0;
    sel_out  = '0;
    unique case (unit_q)
      2'd0: begin sel_flag = Arith_Flag; sel_out = Arith_OUT; end
      2'd1: begin sel_flag = Logic_Flag; sel_out = Logic_OUT; end
      2'd2: begin sel_flag = CMP_Flag;   sel_out = CMP_OUT;   end
      2'd3: begin sel_flag = SHIFT_Flag; sel_out = SHIFT_OUT; end
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned (no latches).
    state_d     = state_q;
    unit_d      = unit_q;
    a_d         = a_q;
    b_d         = b_q;
    fun_d       = fun_q;
    en_d        = '0;
    cmd_ready_d = cmd_ready_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_unit_d  = res_unit_q;
    res_err_d   = res_err_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          a_d         = cmd_a;
          b_d         = cmd_b;
          fun_d       = cmd_fun[1:0];
          unit_d      = cmd_fun[3:2];
          en_d        = 4'b0001 << cmd_fun[3:2];
          cmd_ready_d = 1'b0;
          state_d     = S_ISSUE;
        end
      end

      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // A flag on the timeout cycle still wins.
        if (sel_flag) begin
          res_data_d  = sel_out;
          res_unit_d  = unit_q;
          res_err_d   = 1'b0;
          res_valid_d = 1'b1;
          state_d     = S_HOLD;
        end else if (cnt_q == CNT_LAST) begin
          res_data_d  = '0;
          res_unit_d  = unit_q;
          res_err_d   = 1'b1;
          res_valid_d = 1'b1;
          state_d     = S_HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_HOLD: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      unit_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      fun_q       <= '0;
      en_q        <= '0;
      cmd_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_unit_q  <= '0;
      res_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      unit_q      <= unit_d;
      a_q         <= a_d;
      b_q         <= b_d;
      fun_q       <= fun_d;
      en_q        <= en_d;
      cmd_ready_q <= cmd_ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_unit_q  <= res_unit_d;
      res_err_q   <= res_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign A            = a_q;
  assign B            = b_q;
  assign ALU_FUN      = fun_q;
  assign Arith_Enable = en_q[0];
  assign Logic_Enable = en_q[1];
  assign CMP_Enable   = en_q[2];
  assign SHIFT_Enable = en_q[3];
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign res_unit     = res_unit_q;
  assign res_err      = res_err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer; the four execution units are modelled as
// one-cycle registered responders returning bench-chosen words.
module tb_alu_cmd_sequencer;

  localparam int WIDTH = 16;

  logic             CLK = 1'b0;
  logic             RST;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_fun;
  logic [WIDTH-1:0] cmd_a, cmd_b;
  logic [WIDTH-1:0] A, B;
  logic [1:0]       ALU_FUN;
  logic             Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable;
  logic             Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag;
  logic             res_valid, res_ready, res_err;
  logic [WIDTH-1:0] res_data;
  logic [1:0]       res_unit;

  logic [WIDTH-1:0] unit_out [4];
  logic [3:0]       pend, flag_resp, spurious, alive;
  logic [3:0]       en_vec;

  int n_tests = 0;
  int n_fail  = 0;

  alu_cmd_sequencer #(.WIDTH(WIDTH), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_fun(cmd_fun),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .A(A), .B(B), .ALU_FUN(ALU_FUN),
    .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable),
    .CMP_Enable(CMP_Enable), .SHIFT_Enable(SHIFT_Enable),
    .Arith_OUT(unit_out[0]), .Logic_OUT(unit_out[1]),
    .CMP_OUT(unit_out[2]), .SHIFT_OUT(unit_out[3]),
    .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag),
    .CMP_Flag(CMP_Flag), .SHIFT_Flag(SHIFT_Flag),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_unit(res_unit), .res_err(res_err)
  );

  always #5 CLK = ~CLK;

  assign en_vec     = {SHIFT_Enable, CMP_Enable, Logic_Enable, Arith_Enable};
  assign Arith_Flag = flag_resp[0] | spurious[0];
  assign Logic_Flag = flag_resp[1] | spurious[1];
  assign CMP_Flag   = flag_resp[2] | spurious[2];
  assign SHIFT_Flag = flag_resp[3] | spurious[3];

  // Unit model: an enable seen in one cycle yields a flag in the following cycle.
  always @(negedge CLK) begin
    flag_resp = pend & alive;
    pend      = en_vec;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_cmd(input logic [3:0] fun, input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("cmd_ready_wait", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_fun   = fun;
    cmd_a     = a;
    cmd_b     = b;
    tick();
    cmd_valid = 1'b0;
    check("acc_cmd_ready", cmd_ready, 1'b0);
    check("acc_A", A, a);
    check("acc_B", B, b);
    check("acc_ALU_FUN", ALU_FUN, fun[1:0]);
    check("acc_enable", en_vec, 4'b0001 << fun[3:2]);
  endtask

  // Returns the number of edges after the accept edge until res_valid shows.
  task automatic wait_result(input int spur_at, output int lat);
    lat = 0;
    while (res_valid !== 1'b1 && lat < 30) begin
      tick();
      lat++;
      if (lat == 1) check("enable_drop", en_vec, 4'b0000);
      if (lat == spur_at) spurious[1] = 1'b1;
      if (lat == spur_at + 2) spurious[1] = 1'b0;
    end
    spurious[1] = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [3:0] fun, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] word, input int exp_lat,
                        input logic exp_err, input int spur_at);
    int lat;
    unit_out[fun[3:2]] = word;
    send_cmd(fun, a, b);
    wait_result(spur_at, lat);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_data"}, res_data, exp_err ? 16'h0000 : word);
    check({tag, "_unit"}, res_unit, fun[3:2]);
    check({tag, "_err"}, res_err, exp_err);
  endtask

  task automatic consume(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_valid_drop"}, res_valid, 1'b0);
    check({tag, "_ready_rise"}, cmd_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    RST       = 1'b0;
    cmd_valid = 1'b0;
    cmd_fun   = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    res_ready = 1'b0;
    pend      = '0;
    flag_resp = '0;
    spurious  = '0;
    alive     = 4'hF;
    unit_out[0] = 16'h0A0A;
    unit_out[1] = 16'h1B1B;
    unit_out[2] = 16'h2C2C;
    unit_out[3] = 16'h3D3D;

    // Reset state
    #12;
    check("rst_outputs", {cmd_ready, res_valid, res_err, res_unit, ALU_FUN, en_vec}, 0);
    check("rst_A_B_data", {A, B, res_data}, 0);
    @(posedge CLK);
    #1 RST = 1'b1;
    tick();
    check("rst_release_ready", cmd_ready, 1'b1);

    // Logic AND: 00F0 & 0FF0 = 00F0
    run_op("and", 4'b0100, 16'h00F0, 16'h0FF0, 16'h00F0, 2, 1'b0, -1);
    consume("and");

    // Back-to-back: ADD 5+(-7) = FFFE, then NOR 0,0 = FFFF; accepts 4 edges apart
    res_ready   = 1'b1;
    unit_out[0] = 16'hFFFE;
    unit_out[1] = 16'hFFFF;
    cmd_valid   = 1'b1;
    cmd_fun     = 4'b0000;
    cmd_a       = 16'h0005;
    cmd_b       = 16'hFFF9;
    tick();
    check("b2b_acc1_enable", en_vec, 4'b0001);
    cmd_fun = 4'b0111;
    cmd_a   = 16'h0000;
    cmd_b   = 16'h0000;
    tick();
    check("b2b_A_stable1", {A, B}, {16'h0005, 16'hFFF9});
    tick();
    check("b2b_res1_valid", res_valid, 1'b1);
    check("b2b_res1_data", res_data, 16'hFFFE);
    check("b2b_res1_unit", res_unit, 2'd0);
    tick();
    check("b2b_ready_back", {cmd_ready, res_valid}, 2'b10);
    check("b2b_A_stable2", {A, B}, {16'h0005, 16'hFFF9});
    tick();
    cmd_valid = 1'b0;
    check("b2b_acc2_ready", cmd_ready, 1'b0);
    check("b2b_acc2_AB", {A, B}, 32'h0);
    check("b2b_acc2_fun", ALU_FUN, 2'd3);
    check("b2b_acc2_enable", en_vec, 4'b0010);
    tick();
    tick();
    check("b2b_res2_valid", res_valid, 1'b1);
    check("b2b_res2_data", res_data, 16'hFFFF);
    check("b2b_res2_unit", res_unit, 2'd1);
    tick();
    res_ready = 1'b0;
    check("b2b_done", {cmd_ready, res_valid}, 2'b10);

    // Backpressure: result held 10 cycles, stray command ignored
    unit_out[3] = 16'h8001;
    send_cmd(4'b1101, 16'h0003, 16'h0004);
    wait_result(-1, lat);
    check("bp_latency", lat, 2);
    check("bp_data0", res_data, 16'h8001);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        cmd_valid = 1'b1;
        cmd_fun   = 4'b0000;
        cmd_a     = 16'h7777;
      end
      tick();
      cmd_valid = 1'b0;
      check("bp_hold", {res_valid, res_data, res_unit, res_err}, {1'b1, 16'h8001, 2'd3, 1'b0});
      check("bp_cmd_ready", cmd_ready, 1'b0);
      if (i == 4) check("bp_ignored", {A, en_vec}, {16'h0003, 4'b0000});
    end
    consume("bp");

    // Timeout: CMP never flags, spurious Logic_Flag ignored; error after 8 WAIT cycles
    alive[2]    = 1'b0;
    unit_out[1] = 16'hBEEF;
    run_op("timeout", 4'b1000, 16'h0001, 16'h0002, 16'h1234, 9, 1'b1, 3);
    consume("timeout");

    // Reset while in WAIT
    send_cmd(4'b1000, 16'h5555, 16'hAAAA);
    tick();
    tick();
    RST = 1'b0;
    #1;
    check("midrst_outputs", {cmd_ready, res_valid, res_err, res_unit, ALU_FUN, en_vec}, 0);
    check("midrst_A_B", {A, B}, 0);
    tick();
    tick();
    RST      = 1'b1;
    alive[2] = 1'b1;
    tick();
    check("midrst_ready", cmd_ready, 1'b1);
    // OR: 0F00 | 00F0 = 0FF0
    run_op("or", 4'b0101, 16'h0F00, 16'h00F0, 16'h0FF0, 2, 1'b0, -1);
    consume("or");

    // Enable exclusivity sweep over all 16 function codes
    for (int f = 0; f < 16; f++) begin
      logic [3:0] fv;
      fv = 4'(f);
      run_op("sweep", fv, {12'h0, fv}, {12'hFFF, ~fv}, {12'hA50, fv}, 2, 1'b0, -1);
      consume("sweep");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
